// File: rtl/multiplier_unit_if.sv
// multiplier_unit_if: operand/result bundle for multiplier_unit; carries busy when MULT_BUSY_EN is defined
interface multiplier_unit_if #(parameter int parallelism = 32);
    logic                       valid;
    logic                       usigned;
    logic [parallelism-1:0]     multiplier;
    logic [parallelism-1:0]     multiplicand;
    logic [2*parallelism-1:0]   product;
    logic                       res_ready;
`ifdef MULT_BUSY_EN
    logic                       busy;
    modport master (output valid, usigned, multiplier, multiplicand, input product, res_ready, busy);
    modport slave  (input valid, usigned, multiplier, multiplicand, output product, res_ready, busy);
`else
    modport master (output valid, usigned, multiplier, multiplicand, input product, res_ready);
    modport slave  (input valid, usigned, multiplier, multiplicand, output product, res_ready);
`endif
endinterface

// File: rtl/multiplier_unit.sv
// multiplier_unit: iterative radix-2 Booth multiplier, signed/unsigned; optional busy output under MULT_BUSY_EN
module multiplier_unit #(parameter int parallelism = 32) (
    input logic              clk,
    input logic              rst,
    multiplier_unit_if.slave bus
);
    localparam int CW = $clog2(parallelism + 2);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [parallelism+1:0]   acc_q, acc_d, mcand_q, mcand_d, sum;
    logic [parallelism:0]     q_q, q_d;
    logic                     qm1_q, qm1_d;
    logic [2*parallelism-1:0] product_q, product_d;
    logic                     ext_a, ext_b;
    // next-state: operand load, one Booth add/sub + arithmetic shift per RUN cycle, result capture
    always_comb begin
        ext_a     = ~bus.usigned & bus.multiplicand[parallelism-1];
        ext_b     = ~bus.usigned & bus.multiplier[parallelism-1];
        sum       = ({q_q[0], qm1_q} == 2'b01) ? acc_q + mcand_q :
                    ({q_q[0], qm1_q} == 2'b10) ? acc_q - mcand_q : acc_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        product_d = product_q;
        if (state_q == IDLE && bus.valid) begin
            mcand_d = {ext_a, ext_a, bus.multiplicand};
            q_d     = {ext_b, bus.multiplier};
            acc_d   = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN && cnt_q == CW'(parallelism + 1)) begin
            product_d = {acc_q[parallelism-2:0], q_q};
            state_d   = DONE;
        end else if (state_q == RUN) begin
            acc_d = {sum[parallelism+1], sum[parallelism+1:1]};
            q_d   = {sum[0], q_q[parallelism:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // state registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            product_q <= product_d;
        end
    end
    assign bus.product   = product_q;
    assign bus.res_ready = state_q == DONE;
`ifdef MULT_BUSY_EN
    assign bus.busy      = state_q != IDLE;
`endif
endmodule

// File: tb/tb_multiplier_unit.sv
// tb_multiplier_unit: vector table, corner sequences and random ops against an arithmetic reference
module tb_multiplier_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    multiplier_unit_if #(.parallelism(32)) bus();
    multiplier_unit #(.parallelism(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic        u;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic u);
        longint sa, sb;
        if (u) return {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(string name, logic [31:0] a, logic [31:0] b, logic u, logic [63:0] exp);
        int n;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.usigned = u;
        bus.multiplicand = a;
        bus.multiplier = b;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.usigned = ~u;
        bus.multiplicand = $urandom;
        bus.multiplier = $urandom;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.res_ready) break;
        end
        check({name, "_latency"}, 64'(n), 64'd34);
        check({name, "_product"}, bus.product, exp);
        @(posedge clk);
        #1;
        check({name, "_pulse_end"}, {63'b0, bus.res_ready}, 64'd0);
        check({name, "_hold"}, bus.product, exp);
    endtask

    initial begin
        int n, pulses, first;
        logic [31:0] ra, rb;
        logic ru;
        vecs[0] = '{1'b0, 32'h00000016, 32'hFFFFFFEB, 64'hFFFFFFFFFFFFFE32};
        vecs[1] = '{1'b1, 32'h00000016, 32'hFFFFFFEB, 64'h00000015FFFFFE32};
        vecs[2] = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[4] = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
        vecs[5] = '{1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0};
        vecs[6] = '{1'b0, 32'h00000001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        bus.valid = 1'b0;
        bus.usigned = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        #12;
        check("reset_product", bus.product, 64'd0);
        check("reset_ready", {63'b0, bus.res_ready}, 64'd0);
`ifdef MULT_BUSY_EN
        check("reset_busy", {63'b0, bus.busy}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].exp);

        // second valid during RUN must be ignored
        @(negedge clk);
        bus.valid = 1'b1;
        bus.usigned = 1'b1;
        bus.multiplicand = 32'd1000;
        bus.multiplier = 32'd77;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        pulses = 0;
        first = 0;
        for (n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                bus.valid = 1'b1;
                bus.multiplicand = 32'd3;
                bus.multiplier = 32'd9;
            end
            if (n == 6) bus.valid = 1'b0;
            if (bus.res_ready) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    check("ignore_product", bus.product, 64'd77000);
                end
            end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_latency", 64'(first), 64'd34);
        check("ignore_final", bus.product, 64'd77000);
        run_op("after_done", 32'd12345, 32'd678, 1'b1, 64'd8369910);

        // reset 10 cycles into RUN aborts the operation
        @(negedge clk);
        bus.valid = 1'b1;
        bus.usigned = 1'b0;
        bus.multiplicand = 32'h00001234;
        bus.multiplier = 32'h00005678;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_product", bus.product, 64'd0);
        check("abort_ready", {63'b0, bus.res_ready}, 64'd0);
`ifdef MULT_BUSY_EN
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.res_ready) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        check("abort_product_held", bus.product, 64'd0);
        run_op("post_reset", 32'd3, 32'd5, 1'b1, 64'hF);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = 32'h80000000 | (ra & 32'h0000000F);
            run_op($sformatf("rand%0d", i), ra, rb, ru, ref_mul(ra, rb, ru));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
